// File: rtl/multi_deque_pkg.sv
// Shared types and encodings for the multi-channel deque block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package multi_deque_pkg;

  // Widths for the default configuration; modules derive their own from parameters.
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int PTR_W        = $clog2(DEF_DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam int CH_W         = $clog2(DEF_CHANNELS);

  localparam logic END_FRONT = 1'b0;
  localparam logic END_BACK  = 1'b1;

  // Already-legalised operation handed to a single channel.
  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_XCHG,
    OP_CLEAR
  } op_e;

  // Raw command bits as seen on the shared port.
  typedef struct packed {
    logic clear;
    logic push;
    logic pop;
    logic end_sel;
  } cmd_t;

endpackage

// File: rtl/multi_deque_channel.sv
// One circular-buffer deque: head/tail pointers, occupancy count, flags.
// Latency: state updates on the clock edge after op; rd_word is combinational.
// Backpressure: none; caller must only issue ops that are legal for empty/full.
module deque_channel
  import multi_deque_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  op_e                      op,
  input  logic                     end_sel,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_word,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] head;
  logic [PTR_BITS-1:0] tail;
  logic [CNT_BITS-1:0] cnt;
  logic [PTR_BITS-1:0] head_m1;
  logic [PTR_BITS-1:0] tail_m1;
  logic [PTR_BITS-1:0] end_idx;
  logic                wr_en;
  logic [PTR_BITS-1:0] wr_idx;

  // Pointer arithmetic wraps naturally modulo DEPTH (power of two).
  assign head_m1 = head - 1'b1;
  assign tail_m1 = tail - 1'b1;

  // The word currently sitting at the selected end (front = head, back = tail-1).
  assign end_idx = (end_sel == END_FRONT) ? head : tail_m1;
  assign rd_word = mem[end_idx];

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_BITS'(DEPTH));
  assign count = cnt;

  // Choose the write slot: push grows the chosen end, exchange overwrites it in place.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = end_idx;
    case (op)
      OP_PUSH: begin
        wr_en  = 1'b1;
        wr_idx = (end_sel == END_FRONT) ? head_m1 : tail;
      end
      OP_XCHG: begin
        wr_en  = 1'b1;
        wr_idx = end_idx;
      end
      default: ;
    endcase
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Pointer and occupancy update; exchange leaves both untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      case (op)
        OP_CLEAR: begin
          head <= '0;
          tail <= '0;
          cnt  <= '0;
        end
        OP_PUSH: begin
          if (end_sel == END_FRONT) head <= head_m1;
          else                      tail <= tail + 1'b1;
          cnt <= cnt + 1'b1;
        end
        OP_POP: begin
          if (end_sel == END_FRONT) head <= head + 1'b1;
          else                      tail <= tail_m1;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_deque.sv
// CHANNELS independent deques behind one shared command port.
// Latency: popped word and out_valid/err strobes register one edge after the command.
// Backpressure: none; illegal push/pop is dropped and flagged on err for one cycle.
module multi_deque
  import multi_deque_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(CHANNELS)-1:0]   chan_select,
  input  logic                          end_select,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          clear,
  input  logic [WIDTH-1:0]              data_in,
  output logic [WIDTH-1:0]              data_out,
  output logic                          out_valid,
  output logic                          err,
  output logic [CHANNELS-1:0]           empty,
  output logic [CHANNELS-1:0]           full,
  output logic [$clog2(DEPTH):0]        sel_count
);

  localparam int CH_BITS  = $clog2(CHANNELS);
  localparam int CNT_BITS = $clog2(DEPTH) + 1;

  cmd_t                cmd;
  op_e                 op_sel;
  logic                cmd_err;
  logic                take_vld;
  logic [WIDTH-1:0]    rd_word  [CHANNELS];
  logic [CNT_BITS-1:0] ch_count [CHANNELS];

  assign cmd = '{clear: clear, push: push, pop: pop, end_sel: end_select};

  // Legalise the command against the selected channel's flags; clear dominates.
  always_comb begin
    op_sel  = OP_NONE;
    cmd_err = 1'b0;
    if (!rst) begin
      if (cmd.clear) begin
        op_sel = OP_CLEAR;
      end else if (cmd.push && cmd.pop) begin
        if (empty[chan_select]) cmd_err = 1'b1;
        else                    op_sel  = OP_XCHG;
      end else if (cmd.push) begin
        if (full[chan_select]) cmd_err = 1'b1;
        else                   op_sel  = OP_PUSH;
      end else if (cmd.pop) begin
        if (empty[chan_select]) cmd_err = 1'b1;
        else                    op_sel  = OP_POP;
      end
    end
  end

  assign take_vld  = (op_sel == OP_POP) || (op_sel == OP_XCHG);
  assign sel_count = ch_count[chan_select];

  // Only the addressed channel sees a non-idle op; the rest hold.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    op_e ch_op;
    assign ch_op = (chan_select == CH_BITS'(i)) ? op_sel : OP_NONE;

    deque_channel #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .op      (ch_op),
      .end_sel (end_select),
      .wr_data (data_in),
      .rd_word (rd_word[i]),
      .empty   (empty[i]),
      .full    (full[i]),
      .count   (ch_count[i])
    );
  end

  // Capture the outgoing word and raise the one-cycle strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= take_vld;
      err       <= cmd_err;
      if (take_vld) begin
        data_out <= rd_word[chan_select];
      end
    end
  end

endmodule

// File: tb/tb_multi_deque.sv
// Directed bench for multi_deque with a scoreboard of expected popped words.
// Latency: checks sample #1 after the edge that follows each command.
// Backpressure: n/a.
module tb_multi_deque;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] chan_select;
  logic       end_select;
  logic       push;
  logic       pop;
  logic       clear;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       out_valid;
  logic       err;
  logic [3:0] empty;
  logic [3:0] full;
  logic [4:0] sel_count;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  multi_deque #(
    .CHANNELS (4),
    .WIDTH    (8),
    .DEPTH    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .chan_select (chan_select),
    .end_select  (end_select),
    .push        (push),
    .pop         (pop),
    .clear       (clear),
    .data_in     (data_in),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .err         (err),
    .empty       (empty),
    .full        (full),
    .sel_count   (sel_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one command for one edge, then check strobes and (if valid) the scoreboard head.
  task automatic cmd(input logic [1:0] ch, input logic e, input logic pu, input logic po,
                     input logic cl, input logic [7:0] d, input logic exp_vld, input logic exp_err);
    chan_select = ch;
    end_select  = e;
    push        = pu;
    pop         = po;
    clear       = cl;
    data_in     = d;
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
    check("out_valid", 32'(out_valid), 32'(exp_vld));
    check("err", 32'(err), 32'(exp_err));
    if (exp_vld) begin
      if (sb.size() > 0) begin
        check("data_out", 32'(data_out), 32'(sb.pop_front()));
      end else begin
        n_assert++;
        n_fail++;
        $error("FAIL scoreboard: observed empty queue expected an entry");
      end
    end
  endtask

  task automatic push_b(input logic [1:0] ch, input logic [7:0] d);
    cmd(ch, 1'b1, 1'b1, 1'b0, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic push_f(input logic [1:0] ch, input logic [7:0] d);
    cmd(ch, 1'b0, 1'b1, 1'b0, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic pop_exp(input logic [1:0] ch, input logic e, input logic [7:0] exp);
    sb.push_back(exp);
    cmd(ch, e, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    chan_select = 2'd0;
    end_select  = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    clear       = 1'b0;
    data_in     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_empty", 32'(empty), 32'hF);
    check("rst_full", 32'(full), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_sel_count", 32'(sel_count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Ch0: mixed-end pushes and pops
    push_b(2'd0, 8'h11);
    push_b(2'd0, 8'h22);
    push_f(2'd0, 8'h33);
    check("ch0_count3", 32'(sel_count), 32'd3);
    pop_exp(2'd0, 1'b0, 8'h33);
    pop_exp(2'd0, 1'b1, 8'h22);
    pop_exp(2'd0, 1'b1, 8'h11);
    check("ch0_empty", 32'(empty[0]), 32'd1);
    check("ch0_count0", 32'(sel_count), 32'd0);

    // Ch2: fill to full, overflow rejected, pop back
    for (int i = 0; i < 16; i++) push_b(2'd2, 8'(i));
    check("ch2_full", 32'(full[2]), 32'd1);
    check("ch2_count16", 32'(sel_count), 32'd16);
    cmd(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1);
    check("ch2_ovf_count", 32'(sel_count), 32'd16);
    check("ch2_ovf_full", 32'(full[2]), 32'd1);
    pop_exp(2'd2, 1'b1, 8'h0F);
    check("ch2_count15", 32'(sel_count), 32'd15);
    check("ch2_not_full", 32'(full[2]), 32'd0);

    // Ch1: underflow and exchange
    cmd(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ch1_underflow_hold", 32'(data_out), 32'h0F);
    cmd(2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
    check("ch1_xchg_empty_count", 32'(sel_count), 32'd0);
    push_b(2'd1, 8'hA0);
    push_b(2'd1, 8'hB0);
    sb.push_back(8'hB0);
    cmd(2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC0, 1'b1, 1'b0);
    check("ch1_xchg_count", 32'(sel_count), 32'd2);
    pop_exp(2'd1, 1'b1, 8'hC0);
    pop_exp(2'd1, 1'b0, 8'hA0);
    check("ch1_drained", 32'(empty[1]), 32'd1);

    // Ch3: front push from head=0 lands in slot 15, back pop from tail=0 reads it
    push_f(2'd3, 8'h55);
    pop_exp(2'd3, 1'b1, 8'h55);
    // FIFO traffic across the wrap point; scoreboard fills on push
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      sb.push_back(8'h70 + 8'(i));
      push_b(2'd3, 8'h70 + 8'(i));
    end
    for (int i = 0; i < 20; i++) begin
      sb.push_back(8'h80 + 8'(i));
      push_b(2'd3, 8'h80 + 8'(i));
      cmd(2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("ch3_count2", 32'(sel_count), 32'd2);
    for (int i = 0; i < 2; i++) cmd(2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("ch3_empty", 32'(empty[3]), 32'd1);

    // Clear ch0 without disturbing ch1
    for (int i = 0; i < 5; i++) push_b(2'd0, 8'h40 + 8'(i));
    for (int i = 0; i < 3; i++) push_b(2'd1, 8'h50 + 8'(i));
    chan_select = 2'd0;
    #1;
    check("ch0_count5", 32'(sel_count), 32'd5);
    cmd(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check("clr_ch0_empty", 32'(empty[0]), 32'd1);
    check("clr_ch0_count", 32'(sel_count), 32'd0);
    chan_select = 2'd1;
    #1;
    check("clr_ch1_count", 32'(sel_count), 32'd3);
    check("clr_ch1_not_empty", 32'(empty[1]), 32'd0);

    // Reset in the middle of a burst, with a legal pop pending
    push_b(2'd2, 8'hE0);
    check("pre_rst_full2", 32'(full[2]), 32'd1);
    rst         = 1'b1;
    chan_select = 2'd1;
    end_select  = 1'b0;
    pop         = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pop = 1'b0;
    check("mid_rst_empty", 32'(empty), 32'hF);
    check("mid_rst_full", 32'(full), 32'h0);
    check("mid_rst_data_out", 32'(data_out), 32'h0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    chan_select = 2'd2;
    #1;
    check("mid_rst_ch2_count", 32'(sel_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
